// File: rtl/seq_detector_pkg.sv
// Shared types and limits for the serial
// pattern detector.
package seq_detector_pkg;

  typedef enum logic {
    S_UNLOADED = 1'b0,
    S_RUN      = 1'b1
  } state_t;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;

endpackage

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter; clear beats
// increment, never wraps.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk_2,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector.sv
// Programmable serial pattern detector with
// overlap select and saturating match count.
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 8
) (
  input  logic                         clk_2,
  input  logic                         reset,
  input  logic                         load,
  input  logic [PAT_LEN-1:0]           pattern_in,
  input  logic                         overlap,
  input  logic                         din,
  input  logic                         din_valid,
  input  logic                         clear_count,
  output logic                         match,
  output logic [CNT_W-1:0]             match_count,
  output logic [$clog2(PAT_LEN+1)-1:0] fill,
  output logic                         armed
);

  localparam int FW = $clog2(PAT_LEN + 1);

  if (PAT_LEN < PAT_LEN_MIN || PAT_LEN > PAT_LEN_MAX) begin : g_bad_len
    $error("seq_detector: PAT_LEN out of range 2..16");
  end

  state_t             state, state_nx;
  logic [PAT_LEN-1:0] pat, pat_nx;
  // Only the newest PAT_LEN-1 bits are kept;
  // the incoming bit completes the window.
  logic [PAT_LEN-2:0] hist, hist_nx;
  logic [PAT_LEN-1:0] nh;
  logic [FW-1:0]      fill_nx;
  logic               match_nx;
  logic               accept;
  logic               hit;

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state <= S_UNLOADED;
      pat   <= '0;
      hist  <= '0;
      fill  <= '0;
      match <= 1'b0;
    end else begin
      state <= state_nx;
      pat   <= pat_nx;
      hist  <= hist_nx;
      fill  <= fill_nx;
      match <= match_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pat_nx   = pat;
    hist_nx  = hist;
    fill_nx  = fill;
    match_nx = 1'b0;
    nh       = {hist, din};
    accept   = (state == S_RUN) && din_valid && !load;
    hit      = accept && (nh == pat) &&
               (fill >= FW'(PAT_LEN - 1));
    unique case (1'b1)
      load: begin
        state_nx = S_RUN;
        pat_nx   = pattern_in;
        hist_nx  = '0;
        fill_nx  = '0;
      end
      accept: begin
        hist_nx  = nh[PAT_LEN-2:0];
        match_nx = hit;
        if (hit && !overlap) begin
          fill_nx = '0;
        end else if (fill != FW'(PAT_LEN)) begin
          fill_nx = fill + 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign armed = (state == S_RUN);

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk_2(clk_2),
    .reset(reset),
    .clr  (clear_count),
    .inc  (hit),
    .q    (match_count)
  );

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: directed
// scenarios plus random stream vs queue model.
module tb_seq_detector;

  localparam int PL = 4;

  logic          clk_2 = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [PL-1:0] pattern_in = '0;
  logic          overlap = 1'b0;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic          clear_count = 1'b0;

  logic          match, match2;
  logic [7:0]    match_count;
  logic [1:0]    match_count2;
  logic [2:0]    fill, fill2;
  logic          armed, armed2;

  seq_detector #(.PAT_LEN(PL), .CNT_W(8)) dut (
    .clk_2(clk_2), .reset(reset), .load(load),
    .pattern_in(pattern_in), .overlap(overlap),
    .din(din), .din_valid(din_valid),
    .clear_count(clear_count), .match(match),
    .match_count(match_count), .fill(fill),
    .armed(armed)
  );

  seq_detector #(.PAT_LEN(PL), .CNT_W(2)) dut2 (
    .clk_2(clk_2), .reset(reset), .load(load),
    .pattern_in(pattern_in), .overlap(overlap),
    .din(din), .din_valid(din_valid),
    .clear_count(clear_count), .match(match2),
    .match_count(match_count2), .fill(fill2),
    .armed(armed2)
  );

  always #5 clk_2 = ~clk_2;

  int checks = 0;
  int errors = 0;

  // Reference model: bits accepted since last restart
  bit          m_armed;
  bit [PL-1:0] m_pat;
  bit          q[$];
  bit          m_match;
  int          m_cnt, m_cnt2, m_fill;

  wire [19:0] obs = {match, match_count, fill, armed,
                     match2, match_count2, fill2, armed2};

  function automatic logic [19:0] exp_v();
    return {m_match, 8'(m_cnt), 3'(m_fill), m_armed,
            m_match, 2'(m_cnt2), 3'(m_fill), m_armed};
  endfunction

  function automatic void model_reset();
    m_armed = 0; m_pat = '0; q.delete();
    m_match = 0; m_cnt = 0; m_cnt2 = 0; m_fill = 0;
  endfunction

  function automatic void model_edge();
    bit hit;
    hit = 0;
    if (load) begin
      m_armed = 1;
      m_pat = pattern_in;
      q.delete();
    end else if (m_armed && din_valid) begin
      q.push_back(din);
      if (q.size() > PL) void'(q.pop_front());
      if (q.size() == PL) begin
        hit = 1;
        for (int i = 0; i < PL; i++)
          if (q[i] != m_pat[PL-1-i]) hit = 0;
      end
      if (hit && !overlap) q.delete();
    end
    m_match = hit;
    if (clear_count) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (hit) begin
      if (m_cnt < 255) m_cnt++;
      if (m_cnt2 < 3) m_cnt2++;
    end
    m_fill = q.size();
  endfunction

  task automatic step(input bit ld, input bit d,
                      input bit dv, input bit ov,
                      input bit clr);
    load = ld; din = d; din_valid = dv;
    overlap = ov; clear_count = clr;
    @(posedge clk_2);
    model_edge();
    #1;
    load = 0; din_valid = 0; clear_count = 0;
  endtask

  task automatic test_reset();
    bit [3:0] s;
    s = 4'b1101;
    model_reset();
    repeat (2) @(posedge clk_2);
    #1;
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL reset_state got %h want %h", obs, 20'h0);
    end
    reset = 0;
    for (int i = 3; i >= 0; i--) begin
      step(0, s[i], 1, 1, 0);
      checks++;
      if (match !== 1'b0 || armed !== 1'b0 || obs !== exp_v()) begin
        errors++;
        $display("FAIL unloaded bit %0d got %h want %h", i, obs, exp_v());
      end
    end
  endtask

  task automatic run_stream(input string name, input bit ov,
                            input bit [6:0] bits,
                            input bit [6:0] want_mask,
                            input int want_cnt,
                            input int want_fill);
    bit [6:0] mask;
    mask = '0;
    pattern_in = 4'b1101;
    step(1, 0, 0, ov, 1);
    for (int i = 0; i < 7; i++) begin
      step(0, bits[6-i], 1, ov, 0);
      mask[i] = match;
      checks++;
      if (obs !== exp_v()) begin
        errors++;
        $display("FAIL %s bit %0d got %h want %h", name, i, obs, exp_v());
      end
    end
    checks++;
    if (mask !== want_mask || match_count !== 8'(want_cnt)
        || fill !== 3'(want_fill)) begin
      errors++;
      $display("FAIL %s end mask %b cnt %0d fill %0d want %b %0d %0d",
               name, mask, match_count, fill,
               want_mask, want_cnt, want_fill);
    end
  endtask

  task automatic test_overlap_on();
    run_stream("overlap_on", 1, 7'b1101101, 7'b1001000, 2, 4);
  endtask

  task automatic test_overlap_off();
    run_stream("overlap_off", 0, 7'b1101101, 7'b0001000, 1, 3);
  endtask

  task automatic test_gapped();
    bit [3:0] s;
    int pulses, pulse_at;
    s = 4'b1101;
    pulses = 0; pulse_at = -1;
    pattern_in = 4'b1101;
    step(1, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, s[3-i], 1, 1, 0);
      if (match) begin pulses++; pulse_at = i * 4; end
      checks++;
      if (obs !== exp_v()) begin
        errors++;
        $display("FAIL gapped bit %0d got %h want %h", i, obs, exp_v());
      end
      for (int g = 0; g < 3; g++) begin
        step(0, 1, 0, 1, 0);
        if (match) begin pulses++; pulse_at = i * 4 + g + 1; end
        checks++;
        if (obs !== exp_v()) begin
          errors++;
          $display("FAIL gapped idle %0d.%0d got %h want %h",
                   i, g, obs, exp_v());
        end
      end
    end
    checks++;
    if (pulses != 1 || pulse_at != 12) begin
      errors++;
      $display("FAIL gapped_pulse count %0d at %0d want 1 at 12",
               pulses, pulse_at);
    end
  endtask

  task automatic test_saturation();
    bit [5:0] mask;
    mask = '0;
    pattern_in = 4'b1111;
    step(1, 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 1, 1, 0);
      mask[i] = match2;
      checks++;
      if (obs !== exp_v()) begin
        errors++;
        $display("FAIL sat bit %0d got %h want %h", i, obs, exp_v());
      end
    end
    checks++;
    if (mask !== 6'b111000 || match_count2 !== 2'd3
        || match_count !== 8'd3) begin
      errors++;
      $display("FAIL sat_end mask %b cnt2 %0d cnt %0d want 111000 3 3",
               mask, match_count2, match_count);
    end
    step(0, 1, 1, 1, 1);
    checks++;
    if (match2 !== 1'b1 || match_count2 !== 2'd0
        || match_count !== 8'd0 || obs !== exp_v()) begin
      errors++;
      $display("FAIL clear_prio got %h want %h", obs, exp_v());
    end
  endtask

  task automatic test_reset_mid();
    pattern_in = 4'b1101;
    step(1, 0, 0, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 1, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    checks++;
    if (fill !== 3'd3 || armed !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset fill %0d armed %b want 3 1", fill, armed);
    end
    #2 reset = 1;
    #1;
    model_reset();
    checks++;
    if (obs !== 20'h0) begin
      errors++;
      $display("FAIL async_reset got %h want %h", obs, 20'h0);
    end
    #1 reset = 0;
    step(1, 1, 1, 1, 0);
    checks++;
    if (fill !== 3'd0 || armed !== 1'b1 || obs !== exp_v()) begin
      errors++;
      $display("FAIL load_preempt got %h want %h", obs, exp_v());
    end
  endtask

  task automatic test_random();
    bit ld, clr;
    for (int i = 0; i < 400; i++) begin
      ld  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 49) == 0);
      if (ld) pattern_in = 4'($urandom_range(0, 15));
      step(ld, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0,
           1'($urandom_range(0, 1)), clr);
      checks++;
      if (obs !== exp_v()) begin
        errors++;
        $display("FAIL random cyc %0d got %h want %h", i, obs, exp_v());
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_overlap_on();
    test_overlap_off();
    test_gapped();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detector.md
# seq_detector

Programmable serial bit-pattern detector with selectable overlap mode and a saturating match counter. It generalises the team's fixed 4-bit "1101" recogniser:

- pattern length is a parameter;
- the pattern itself is loaded at run time;
- input bits are qualified by a valid strobe;
- the matcher does not lose partial matches on a mismatch.

It sits between the switch/serial-input logic and the LED/LCD status outputs on the `clk_2` domain.

## Interface
Parameters:
- `PAT_LEN`, 4: pattern length in bits, legal range 2..16.
- `CNT_W`, 8: width of the match counter.

Ports:
- `clk_2` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `load` in 1: capture `pattern_in` and restart detection.
- `pattern_in` in `PAT_LEN`: pattern; bit `PAT_LEN-1` is the first bit expected on `din`.
- `overlap` in 1: 1 = overlapping matches allowed; 0 = history restarts after each match.
- `din` in 1: serial data bit.
- `din_valid` in 1: `din` is accepted on an edge where this is 1.
- `clear_count` in 1: synchronous clear of `match_count`.
- `match` out 1: one-cycle pulse per detected occurrence.
- `match_count` out `CNT_W`: saturating count of matches.
- `fill` out `$clog2(PAT_LEN+1)`: number of valid history bits, saturates at `PAT_LEN`.
- `armed` out 1: a pattern has been loaded since reset.

## Operation
- **FSM states:** `S_UNLOADED` (reset state) and `S_RUN`.
  - `S_UNLOADED` → `S_RUN` on `load`.
  - In `S_RUN`, `load` re-enters `S_RUN` with a fresh restart.
  - `armed` = (state == `S_RUN`).
- **In `S_UNLOADED`:** `din_valid` is ignored, and `hist`, `fill` and `match` stay 0.
- **`load` (any state):**
  - `pat` <= `pattern_in`; `hist` <= 0; `fill` <= 0; `match` <= 0.
  - If `din_valid` is high on the same edge, `load` wins and that bit is discarded.
- **Accepted bit** (`S_RUN`, `din_valid`, no `load`):
  - `nh` = {`hist[PAT_LEN-2:0]`, `din`}.
  - `hit` = (`nh` == `pat`) and (`fill` >= `PAT_LEN-1`).
  - `hist` <= `nh`.
  - `match` <= `hit`.
  - `fill` update:
    - `hit` and `overlap`=0: `fill` <= 0.
    - otherwise: `fill` <= min(`fill`+1, `PAT_LEN`).
- **Edge with no accepted bit:** `match` <= 0; `hist` and `fill` hold.
- **`overlap`:** sampled on the same edge as the completing bit; it may change freely between bits.
- **`match_count`:**
  - Increments by 1 on each edge where `hit`=1.
  - Saturates at 2^`CNT_W`-1 and never wraps.
  - `clear_count` zeroes it. If `clear_count` and `hit` coincide, the clear wins (count = 0), but the `match` pulse still fires.
  - `match_count` is not affected by `load`.
- **Reset values:** `pat`=0, `hist`=0, `fill`=0, `match`=0, `match_count`=0, `armed`=0, state=`S_UNLOADED`.
  - Reset mid-stream discards every partial match immediately, with no edge required.

## Timing
- **Latency:** `match` is registered. It is high during the cycle after the edge that accepts the final pattern bit, for exactly one cycle.
- **Counter alignment:** `match_count` reflects the new value in the same cycle that `match` is high.
- **Back-to-back pulses:** two matches on consecutive accepted bits give `match` high for two consecutive cycles. This needs `overlap`=1 and a periodic pattern, e.g. "1111".
- **Idle cycles:** gaps in `din_valid` do not break a partial match; history is held.
- **Combinational outputs:** none. All outputs come straight from flops.

## Structure
- **Package `seq_detector_pkg`:** holds `typedef enum logic {S_UNLOADED, S_RUN} state_t`, `PAT_LEN_MIN`=2 and `PAT_LEN_MAX`=16.
- **Sub-module `sat_counter`** (parameter `W`; ports `clk_2`, `reset`, `clr`, `inc`, `q`): a saturating up-counter with clear priority, instantiated for `match_count`.
- **Elaboration check:** assert 2 <= `PAT_LEN` <= 16.

## Test plan
1. **Overlap on.** `load` "1101" (`PAT_LEN`=4), `overlap`=1, stream 1,1,0,1,1,0,1 with `din_valid` every cycle.
   - `match` pulses after bits 4 and 7.
   - `match_count`=2; `fill`=4 at end.
2. **Overlap off.** Same stream with `overlap`=0.
   - Single pulse after bit 4; `match_count`=1; `fill`=3 at end.
3. **Gapped input.** Stream "1101" with `din_valid` low for 3 cycles between each bit.
   - One pulse, one cycle after the 4th accepted bit; no pulses during gaps.
4. **Saturation and clear priority.** `CNT_W`=2, `overlap`=1, pattern "1111", stream of 6 ones.
   - Pulses after bits 4, 5, 6; `match_count` sticks at 3.
   - `clear_count` asserted with the next hit: `match` pulses and `match_count`=0.
5. **Reset and `load` preemption.**
   - Before any `load`, stream "1101": no `match`, `armed`=0.
   - After `load`, send "110", then assert async `reset` mid-cycle: all outputs 0 immediately, state `S_UNLOADED`.
   - `load` on the same edge as a valid bit: the bit is dropped and `fill` stays 0.
